// File: rtl/pixel_dispatch_stage_pkg.sv
// Shared types and widths for the pixel dispatch stage and its raster counter.
package pixel_dispatch_stage_pkg;

  // Pixel coordinate widths shared with the primary-ray stage.
  localparam int unsigned PX_WIDTH = 10;
  localparam int unsigned PY_WIDTH = 9;

  // Dispatch sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RISE,
    WAIT_RET,
    ADVANCE
  } dispatch_state_t;

endpackage

// File: rtl/pixel_dispatch_stage_raster_counter.sv
// Raster-order (x fastest) pixel coordinate counter with end-of-row/column flags.
module raster_counter
  import pixel_dispatch_stage_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                inc,
  output logic [PX_WIDTH-1:0] px,
  output logic [PY_WIDTH-1:0] py,
  output logic                last_x,
  output logic                last_y
);

  localparam logic [PX_WIDTH-1:0] X_LAST = PX_WIDTH'(IMG_W - 1);
  localparam logic [PY_WIDTH-1:0] Y_LAST = PY_WIDTH'(IMG_H - 1);

  // End-of-row / end-of-column detection against the configured image size.
  always_comb begin
    last_x = (px == X_LAST);
    last_y = (py == Y_LAST);
  end

  // Coordinate registers: clear to origin, or step one pixel in raster order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px <= '0;
      py <= '0;
    end else if (clear) begin
      px <= '0;
      py <= '0;
    end else if (inc) begin
      if (last_x) begin
        px <= '0;
        py <= py + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_dispatch_stage.sv
// Frame scheduler: issues one primary-ray start per pixel in raster order and
// waits for both ray generation and downstream pixel completion before advancing.
module pixel_dispatch_stage
  import pixel_dispatch_stage_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                abort,
  output logic                frame_busy,
  output logic                frame_done,
  output logic [PX_WIDTH-1:0] px,
  output logic [PY_WIDTH-1:0] py,
  output logic                prim_start,
  input  logic                prim_busy,
  input  logic                pix_done
);

  dispatch_state_t state, state_nxt;
  logic gen_seen, gen_nxt;
  logic pix_seen, pix_nxt;
  logic done_nxt;
  logic cnt_clear, cnt_inc;
  logic last_x, last_y;

  raster_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_raster (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .px     (px),
    .py     (py),
    .last_x (last_x),
    .last_y (last_y)
  );

  // Next-state, sticky completion flags and counter control; abort overrides all.
  always_comb begin
    state_nxt = state;
    gen_nxt   = gen_seen;
    pix_nxt   = pix_seen;
    done_nxt  = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          cnt_clear = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        gen_nxt   = 1'b0;
        pix_nxt   = 1'b0;
        state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (pix_done)  pix_nxt = 1'b1;
        if (prim_busy) state_nxt = WAIT_RET;
      end
      WAIT_RET: begin
        if (!prim_busy) gen_nxt = 1'b1;
        if (pix_done)   pix_nxt = 1'b1;
        // Same-cycle arrival of either event counts immediately.
        if (gen_nxt && pix_nxt) state_nxt = ADVANCE;
      end
      ADVANCE: begin
        if (last_x && last_y) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;
    end
  end

  // State, flags and registered outputs (derived from the next state so they align with it).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gen_seen   <= 1'b0;
      pix_seen   <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      prim_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      gen_seen   <= gen_nxt;
      pix_seen   <= pix_nxt;
      frame_busy <= (state_nxt != IDLE);
      frame_done <= done_nxt;
      prim_start <= (state_nxt == ISSUE);
    end
  end

endmodule

// File: tb/tb_pixel_dispatch_stage.sv
// Directed/randomized bench for pixel_dispatch_stage with a cycle-level timing model.
module tb_pixel_dispatch_stage;
  import pixel_dispatch_stage_pkg::*;

  localparam int W = 4;
  localparam int H = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_start = 1'b0, abort = 1'b0;
  logic prim_busy = 1'b0, pix_done = 1'b0;
  logic frame_busy, frame_done, prim_start;
  logic [PX_WIDTH-1:0] px;
  logic [PY_WIDTH-1:0] py;

  logic fs1 = 1'b0, ab1 = 1'b0, busy1 = 1'b0, pd1 = 1'b0;
  logic fb1, fd1, ps1;
  logic [PX_WIDTH-1:0] px1;
  logic [PY_WIDTH-1:0] py1;

  pixel_dispatch_stage #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
    .frame_busy(frame_busy), .frame_done(frame_done), .px(px), .py(py),
    .prim_start(prim_start), .prim_busy(prim_busy), .pix_done(pix_done)
  );

  pixel_dispatch_stage #(.IMG_W(1), .IMG_H(1)) dut1 (
    .clk(clk), .rst(rst), .frame_start(fs1), .abort(ab1),
    .frame_busy(fb1), .frame_done(fd1), .px(px1), .py(py1),
    .prim_start(ps1), .prim_busy(busy1), .pix_done(pd1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int starts = 0, dones = 0, starts1 = 0, dones1 = 0;
  int compared = 0, mismatched = 0;

  // Cycle and pulse counters, sampled with pre-edge output values.
  always @(posedge clk) begin
    cyc++;
    if (prim_start) starts++;
    if (frame_done) dones++;
    if (ps1) starts1++;
    if (fd1) dones1++;
  end

  // Downstream model: busy rises 1 cycle after start for 8 cycles; pix_done after pd_offset cycles.
  int pd_offset = 12;
  int cnt_a = 0, timer_a = 0;
  bit seen_a = 0;
  always @(negedge clk) begin
    pix_done = 1'b0;
    if (timer_a > 0) begin
      timer_a--;
      if (timer_a == 0) pix_done = 1'b1;
    end
    if (seen_a) begin cnt_a = 8; seen_a = 0; end
    else if (cnt_a > 0) cnt_a--;
    prim_busy = (cnt_a != 0);
    if (prim_start) begin seen_a = 1; timer_a = pd_offset; end
  end

  int cnt_b = 0, timer_b = 0;
  bit seen_b = 0;
  always @(negedge clk) begin
    pd1 = 1'b0;
    if (timer_b > 0) begin
      timer_b--;
      if (timer_b == 0) pd1 = 1'b1;
    end
    if (seen_b) begin cnt_b = 8; seen_b = 0; end
    else if (cnt_b > 0) cnt_b--;
    busy1 = (cnt_b != 0);
    if (ps1) begin seen_b = 1; timer_b = 12; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  bit alt = 0;
  // pix_done delay after start: 0 fixed-late, 1 random (incl. during WAIT_RISE), 2 alternating early/coincident.
  function automatic int pick(input int kind);
    if (kind == 0) return 12;
    if (kind == 1) return int'($urandom_range(14, 1));
    alt = !alt;
    return alt ? 4 : 9;
  endfunction

  // Start a frame and follow n_pix pixels; the model predicts each start at
  // previous start + max(gen end, pix_done) + 2.
  task automatic run_frame(input int n_pix, input int kind, input int poke_idx,
                           input int last_off, output int t_last);
    int off, off_next, expect_cyc, t, waited, s0;
    s0 = starts;
    t_last = 0;
    off = (n_pix == 1 && last_off >= 0) ? last_off : pick(kind);
    pd_offset = off;
    frame_start = 1'b1;
    expect_cyc = cyc + 1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < n_pix; i++) begin
      waited = 0;
      while (prim_start !== 1'b1 && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      t = cyc;
      chk("start_time", t, expect_cyc);
      chk("px", px, i % W);
      chk("py", py, i / W);
      chk("busy_in_frame", frame_busy, 1);
      @(negedge clk);
      chk("start_width", prim_start, 0);
      off_next = (i + 1 == n_pix - 1 && last_off >= 0) ? last_off : pick(kind);
      pd_offset = off_next;
      if (i == poke_idx) begin
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
      end
      expect_cyc = t + max2(9, off) + 2;
      off = off_next;
      t_last = t;
    end
    if (n_pix == W * H) begin
      waited = 0;
      while (frame_done !== 1'b1 && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      chk("done_time", cyc, expect_cyc);
      chk("busy_at_done", frame_busy, 0);
      chk("frame_starts", starts - s0, W * H);
      @(negedge clk);
      chk("done_width", frame_done, 0);
      chk("busy_after", frame_busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, s0, d0, waited;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", frame_busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_start", prim_start, 0);
    chk("rst_px", px, 0);
    chk("rst_py", py, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Full frame, pix_done 3 cycles after busy falls
    run_frame(W * H, 0, -1, -1, t);
    // pix_done during busy and coincident with its fall
    run_frame(W * H, 2, -1, -1, t);
    // frame_start while busy at pixel (2,0) is ignored
    d0 = dones;
    run_frame(W * H, 0, 2, -1, t);
    chk("poke_one_done", dones - d0, 1);

    // Abort in WAIT_RET at pixel (1,0); pix_done withheld
    run_frame(2, 0, -1, 0, t);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", frame_busy, 0);
    chk("abort_start", prim_start, 0);
    chk("abort_px", px, 1);
    chk("abort_py", py, 0);
    s0 = starts;
    d0 = dones;
    repeat (20) @(negedge clk);
    chk("abort_no_start", starts - s0, 0);
    chk("abort_no_done", dones - d0, 0);
    chk("abort_hold_px", px, 1);

    // frame_start together with abort in IDLE: stays idle
    frame_start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    abort = 1'b0;
    chk("fs_abort_busy", frame_busy, 0);
    repeat (3) @(negedge clk);
    chk("fs_abort_starts", starts - s0, 0);

    // Restart after abort, random pix_done timing
    run_frame(W * H, 1, -1, -1, t);

    // Reset mid-frame at pixel (2,1)
    run_frame(6 + 1, 0, -1, -1, t);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", frame_busy, 0);
    chk("arst_start", prim_start, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_px", px, 0);
    chk("arst_py", py, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_idle", frame_busy, 0);
    run_frame(W * H, 1, -1, -1, t);
    run_frame(W * H, 1, -1, -1, t);

    // 1x1 frame on the second instance
    repeat (5) @(negedge clk);
    s0 = starts1;
    d0 = dones1;
    fs1 = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    fs1 = 1'b0;
    chk("one_start", ps1, 1);
    chk("one_px", px1, 0);
    chk("one_py", py1, 0);
    waited = 0;
    while (fd1 !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("one_done_time", cyc, t + 14);
    chk("one_busy_at_done", fb1, 0);
    repeat (10) @(negedge clk);
    chk("one_starts", starts1 - s0, 1);
    chk("one_dones", dones1 - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
